// File: rtl/instruction_pkg.sv
// Shared RV32I memory-op encodings, M-stage state type and decode helpers.
package instruction_pkg;

  // minst[3:2] prefix marking "no memory operation"
  localparam logic [1:0] MINST_NONE = 2'b11;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  // True for the five supported load encodings
  function automatic logic is_load(input logic [3:0] minst);
    is_load = 1'b0;
    if (minst[3] == 1'b0) begin
      case (minst[2:0])
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_load = 1'b1;
        default:                             is_load = 1'b0;
      endcase
    end
  endfunction

  // Halfwords need an even address, words a multiple of four
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_LH, F3_LHU: is_misaligned = lane[0];
      F3_LW:         is_misaligned = |lane;
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a little-endian word and extends it.
module load_align
  import instruction_pkg::*;
(
  input  logic [2:0]  minst,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension by load type
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (minst)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {{24{1'b0}}, byte_sel};
      F3_LHU:  result = {{16{1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// RV32I memory stage: registers execution results, runs loads over a req/ack
// data-memory port, aligns load data and emits one writeback beat per instruction.
module memory_access
  import instruction_pkg::*;
#(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         minst_i,
  input  logic [31:0]        addr_i,
  input  logic [4:0]         rd_i,
  input  logic               rdm_v_i,
  output logic               mem_stall,
  output logic               dmem_req,
  output logic [DMEM_AW-1:0] dmem_addr,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_v,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign
);

  mstate_t     state;

  // M registers for non-load results, emitted on the following edge
  logic        m_upd;
  logic        m_wbv;
  logic        m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  // Outstanding-load context
  logic [2:0]  ld_f3;
  logic [1:0]  ld_lane;
  logic [4:0]  ld_rd;
  logic        ld_v;
  logic [31:0] ld_result;

  logic        accept;
  logic        in_load;
  logic        in_mis;

  assign mem_stall = (state == M_WAIT) && !dmem_ack;

  // Decode of the instruction offered by the execution stage
  always_comb begin
    accept  = !mem_stall;
    in_load = is_load(minst_i);
    in_mis  = in_load && is_misaligned(minst_i[2:0], addr_i[1:0]);
  end

  load_align u_load_align (
    .minst  (ld_f3),
    .addr   (ld_lane),
    .rdata  (dmem_rdata),
    .result (ld_result)
  );

  // Non-load results pass through the M registers so that an instruction accepted on
  // the ack edge writes back one cycle after the load, never colliding with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= M_IDLE;
      dmem_req  <= 1'b0;
      dmem_addr <= '0;
      wb_v      <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      m_upd     <= 1'b0;
      m_wbv     <= 1'b0;
      m_mis     <= 1'b0;
      m_rd      <= '0;
      m_data    <= '0;
      ld_f3     <= '0;
      ld_lane   <= '0;
      ld_rd     <= '0;
      ld_v      <= 1'b0;
    end else begin
      wb_v     <= m_wbv;
      misalign <= m_mis;
      if (m_upd) begin
        wb_rd   <= m_rd;
        wb_data <= m_data;
      end
      m_upd <= 1'b0;
      m_wbv <= 1'b0;
      m_mis <= 1'b0;

      if (state == M_WAIT && dmem_ack) begin
        state    <= M_IDLE;
        dmem_req <= 1'b0;
        wb_v     <= ld_v;
        wb_rd    <= ld_rd;
        wb_data  <= ld_result;
      end

      if (accept) begin
        if (in_load && !in_mis) begin
          state     <= M_WAIT;
          dmem_req  <= 1'b1;
          dmem_addr <= {addr_i[DMEM_AW-1:2], 2'b00};
          ld_f3     <= minst_i[2:0];
          ld_lane   <= addr_i[1:0];
          ld_rd     <= rd_i;
          ld_v      <= rdm_v_i;
        end else if (in_load) begin
          m_mis <= 1'b1;
        end else begin
          m_upd  <= 1'b1;
          m_rd   <= rd_i;
          m_data <= addr_i;
          m_wbv  <= (minst_i[3:2] == MINST_NONE) && rdm_v_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus a randomized
// instruction stream scored against an in-order expected-event model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  minst_i;
  logic [31:0] addr_i;
  logic [4:0]  rd_i;
  logic        rdm_v_i;
  logic        mem_stall;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct packed {
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  always #5 clk = ~clk;

  memory_access #(.DMEM_AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .minst_i    (minst_i),
    .addr_i     (addr_i),
    .rd_i       (rd_i),
    .rdm_v_i    (rdm_v_i),
    .mem_stall  (mem_stall),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .wb_v       (wb_v),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .misalign   (misalign)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    minst_i = 4'b1100;
    addr_i  = '0;
    rd_i    = '0;
    rdm_v_i = 1'b0;
  endtask

  // Contents of the bench memory: a fixed hash of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Expected load result derived from the byte/halfword/word rules
  function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (int'(off) * 8)) & 32'hFF;
    h = (w >> ((int'(off) / 2) * 16)) & 32'hFFFF;
    case (f3)
      3'd0:    fmt = (b >= 128)   ? b - 256   : b;
      3'd1:    fmt = (h >= 32768) ? h - 65536 : h;
      3'd4:    fmt = b;
      3'd5:    fmt = h;
      default: fmt = w;
    endcase
  endfunction

  // Offers one load (IDLE expected on entry), acks it after 'delay' empty req cycles
  task automatic run_load(input logic [3:0] mi, input logic [31:0] a, input logic [4:0] rd,
                          input logic v, input logic [31:0] rdata, input int unsigned delay,
                          output logic [31:0] got_addr, output int unsigned stalls,
                          output logic got_v, output logic [4:0] got_rd, output logic [31:0] got_data);
    minst_i = mi; addr_i = a; rd_i = rd; rdm_v_i = v;
    step();
    nop();
    got_addr = dmem_addr;
    stalls   = 0;
    for (int unsigned i = 0; i < delay; i++) begin
      dmem_ack = 1'b0;
      #1;
      if (mem_stall) stalls++;
      step();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = rdata;
    step();
    dmem_ack = 1'b0;
    got_v    = wb_v;
    got_rd   = wb_rd;
    got_data = wb_data;
  endtask

  task automatic test_reset();
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0; nop();
    step(); step();
    tests++;
    if ({dmem_req, wb_v, misalign, mem_stall, dmem_addr, wb_rd, wb_data} !== '0) begin
      fails++;
      $display("FAIL reset_state: req=%b wb_v=%b mis=%b stall=%b addr=%h rd=%0d data=%h, all required 0",
               dmem_req, wb_v, misalign, mem_stall, dmem_addr, wb_rd, wb_data);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_alu();
    minst_i = 4'b1100; addr_i = 32'h1234_5678; rd_i = 5'd5; rdm_v_i = 1'b1;
    step();
    nop();
    step();
    tests++;
    if ({wb_v, wb_rd, wb_data, dmem_req} !== {1'b1, 5'd5, 32'h1234_5678, 1'b0}) begin
      fails++;
      $display("FAIL alu_wb: wb_v=%b rd=%0d data=%h req=%b, required 1/5/12345678/0", wb_v, wb_rd, wb_data, dmem_req);
    end
    step();
    tests++;
    if (wb_v !== 1'b0) begin
      fails++;
      $display("FAIL alu_pulse: wb_v=%b, required 0", wb_v);
    end
  endtask

  task automatic test_lw();
    logic [31:0] ga; int unsigned st; logic gv; logic [4:0] gr; logic [31:0] gd;
    run_load(4'b0010, 32'h100, 5'd9, 1'b1, 32'hDEAD_BEEF, 1, ga, st, gv, gr, gd);
    tests++;
    if ({ga, st, gv, gr, gd} !== {32'h100, 32'd1, 1'b1, 5'd9, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL lw: addr=%h stalls=%0d wb_v=%b rd=%0d data=%h, required 100/1/1/9/deadbeef", ga, st, gv, gr, gd);
    end
    tests++;
    if (dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL lw_req_drop: req=%b, required 0", dmem_req);
    end
    step();
    tests++;
    if (wb_v !== 1'b0) begin
      fails++;
      $display("FAIL lw_pulse: wb_v=%b, required 0", wb_v);
    end
  endtask

  task automatic test_lb_lh();
    logic [31:0] ga; int unsigned st; logic gv; logic [4:0] gr; logic [31:0] gd;
    logic [3:0]  mi[4]   = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
    logic [31:0] ad[4]   = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] rdat[4] = '{32'h80FF_FFFF, 32'h80FF_FFFF, 32'h8001_0000, 32'h8001_0000};
    logic [31:0] exp[4]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 4; i++) begin
      run_load(mi[i], ad[i], 5'd3, 1'b1, rdat[i], 0, ga, st, gv, gr, gd);
      tests++;
      if ({ga, gv, gd} !== {32'h100, 1'b1, exp[i]}) begin
        fails++;
        $display("FAIL load_fmt[%0d]: addr=%h wb_v=%b data=%h, required 100/1/%h", i, ga, gv, gd, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_misalign();
    logic [3:0]  mi[3] = '{4'b0001, 4'b0101, 4'b0010};
    logic [31:0] ad[3] = '{32'h101, 32'h203, 32'h102};
    for (int i = 0; i < 3; i++) begin
      minst_i = mi[i]; addr_i = ad[i]; rd_i = 5'd4; rdm_v_i = 1'b1;
      step();
      nop();
      step();
      tests++;
      if ({misalign, wb_v, dmem_req, mem_stall} !== 4'b1000) begin
        fails++;
        $display("FAIL misalign[%0d]: mis=%b wb_v=%b req=%b stall=%b, required 1/0/0/0",
                 i, misalign, wb_v, dmem_req, mem_stall);
      end
      step();
      tests++;
      if ({misalign, wb_v, dmem_req} !== 3'b000) begin
        fails++;
        $display("FAIL misalign_pulse[%0d]: mis=%b wb_v=%b req=%b, required 0/0/0", i, misalign, wb_v, dmem_req);
      end
    end
  endtask

  task automatic test_stall_hold();
    int unsigned st = 0;
    int unsigned bad_wb = 0;
    minst_i = 4'b0010; addr_i = 32'h40; rd_i = 5'd6; rdm_v_i = 1'b1;
    step();
    minst_i = 4'b1101; addr_i = 32'hCAFE_0001; rd_i = 5'd7; rdm_v_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1'b0;
      #1;
      if (mem_stall) st++;
      if (wb_v) bad_wb++;
      step();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
    #1;
    tests++;
    if ({st, bad_wb, mem_stall} !== {32'd3, 32'd0, 1'b0}) begin
      fails++;
      $display("FAIL stall_cycles: stalls=%0d early_wb=%0d stall_at_ack=%b, required 3/0/0", st, bad_wb, mem_stall);
    end
    step();
    nop();
    dmem_ack = 1'b0;
    tests++;
    if ({wb_v, wb_rd, wb_data} !== {1'b1, 5'd6, 32'h0BAD_F00D}) begin
      fails++;
      $display("FAIL stall_load_wb: wb_v=%b rd=%0d data=%h, required 1/6/0badf00d", wb_v, wb_rd, wb_data);
    end
    step();
    tests++;
    if ({wb_v, wb_rd, wb_data} !== {1'b1, 5'd7, 32'hCAFE_0001}) begin
      fails++;
      $display("FAIL stall_alu_wb: wb_v=%b rd=%0d data=%h, required 1/7/cafe0001", wb_v, wb_rd, wb_data);
    end
    step(); step();
    tests++;
    if (wb_v !== 1'b0) begin
      fails++;
      $display("FAIL stall_alu_once: wb_v=%b, required 0", wb_v);
    end
  endtask

  task automatic test_back_to_back();
    minst_i = 4'b0010; addr_i = 32'h200; rd_i = 5'd10; rdm_v_i = 1'b1;
    step();
    minst_i = 4'b0100; addr_i = 32'h305; rd_i = 5'd11; rdm_v_i = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    nop();
    dmem_rdata = 32'h00AB_CD00;
    tests++;
    if ({wb_v, wb_rd, wb_data, dmem_req, dmem_addr} !== {1'b1, 5'd10, 32'h1111_2222, 1'b1, 32'h304}) begin
      fails++;
      $display("FAIL b2b_first: wb_v=%b rd=%0d data=%h req=%b addr=%h, required 1/10/11112222/1/304",
               wb_v, wb_rd, wb_data, dmem_req, dmem_addr);
    end
    step();
    dmem_ack = 1'b0;
    tests++;
    if ({wb_v, wb_rd, wb_data, dmem_req} !== {1'b1, 5'd11, 32'h0000_00CD, 1'b0}) begin
      fails++;
      $display("FAIL b2b_second: wb_v=%b rd=%0d data=%h req=%b, required 1/11/000000cd/0",
               wb_v, wb_rd, wb_data, dmem_req);
    end
    step();
  endtask

  task automatic test_rd0_load();
    logic [31:0] ga; int unsigned st; logic gv; logic [4:0] gr; logic [31:0] gd;
    run_load(4'b0010, 32'h88, 5'd0, 1'b0, 32'h5555_AAAA, 2, ga, st, gv, gr, gd);
    tests++;
    if ({ga, st, gv} !== {32'h88, 32'd2, 1'b0}) begin
      fails++;
      $display("FAIL rd0_load: addr=%h stalls=%0d wb_v=%b, required 88/2/0", ga, st, gv);
    end
    step();
  endtask

  task automatic test_reset_wait();
    minst_i = 4'b0010; addr_i = 32'h500; rd_i = 5'd12; rdm_v_i = 1'b1;
    step();
    nop();
    tests++;
    if ({dmem_req, mem_stall} !== 2'b11) begin
      fails++;
      $display("FAIL rst_wait_pre: req=%b stall=%b, required 1/1", dmem_req, mem_stall);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    tests++;
    if ({dmem_req, mem_stall} !== 2'b00) begin
      fails++;
      $display("FAIL rst_wait_req: req=%b stall=%b, required 0/0", dmem_req, mem_stall);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_7777;
    step();
    step();
    dmem_ack = 1'b0;
    tests++;
    if ({wb_v, misalign, dmem_req, mem_stall} !== 4'b0000) begin
      fails++;
      $display("FAIL rst_wait_late_ack: wb_v=%b mis=%b req=%b stall=%b, required 0/0/0/0",
               wb_v, misalign, dmem_req, mem_stall);
    end
    step();
    tests++;
    if ({wb_v, dmem_req} !== 2'b00) begin
      fails++;
      $display("FAIL stray_ack_idle: wb_v=%b req=%b, required 0/0", wb_v, dmem_req);
    end
  endtask

  task automatic test_random();
    ev_t         q[$];
    ev_t         e;
    logic [31:0] exp_addr = '0;
    int unsigned issued = 0, cycles = 0, dly = 0, sz;
    bit          need_new = 1'b1, have = 1'b0, bad;
    logic [3:0]  mi;
    logic [31:0] a;
    logic [4:0]  rd;
    logic        v;
    nop();
    while ((issued < 300 || have || q.size() != 0 || dmem_req) && cycles < 5000) begin
      cycles++;
      if (!have && issued < 300) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: begin
            case ($urandom_range(0, 4))
              0: mi = 4'b0000;
              1: mi = 4'b0001;
              2: mi = 4'b0010;
              3: mi = 4'b0100;
              default: mi = 4'b0101;
            endcase
          end
          6, 7, 8: mi = {2'b11, 2'($urandom_range(0, 3))};
          default: begin
            case ($urandom_range(0, 5))
              0: mi = 4'b0011;
              1: mi = 4'b0110;
              2: mi = 4'b0111;
              default: mi = {2'b10, 2'($urandom_range(0, 3))};
            endcase
          end
        endcase
        a  = $urandom;
        rd = 5'($urandom_range(0, 31));
        v  = (rd != 0) && ($urandom_range(0, 3) != 0);
        minst_i = mi; addr_i = a; rd_i = rd; rdm_v_i = v;
        have = 1'b1;
      end else if (!have) begin
        nop();
      end
      if (dmem_req) begin
        if (need_new) begin
          dly = $urandom_range(0, 3);
          need_new = 1'b0;
        end
        dmem_ack   = (dly == 0);
        dmem_rdata = mem_word(dmem_addr);
        if (dly != 0) dly--;
        else need_new = 1'b1;
      end else begin
        dmem_ack   = ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
      end
      #1;
      tests++;
      if (wb_v && misalign) begin
        fails++;
        $display("FAIL rnd_exclusive: wb_v=%b mis=%b at cycle %0d, required not both", wb_v, misalign, cycles);
      end
      if (wb_v || misalign) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rnd_unexpected: wb_v=%b mis=%b rd=%0d data=%h, required no event", wb_v, misalign, wb_rd, wb_data);
        end else begin
          e = q.pop_front();
          if (e.mis) bad = (misalign !== 1'b1);
          else bad = (wb_v !== 1'b1) || (wb_rd !== e.rd) || (wb_data !== e.data);
          if (bad) begin
            fails++;
            $display("FAIL rnd_event: wb_v=%b mis=%b rd=%0d data=%h, required mis=%b rd=%0d data=%h",
                     wb_v, misalign, wb_rd, wb_data, e.mis, e.rd, e.data);
          end
        end
      end
      if (dmem_req) begin
        tests++;
        if (dmem_addr !== exp_addr) begin
          fails++;
          $display("FAIL rnd_addr: dmem_addr=%h, required %h", dmem_addr, exp_addr);
        end
      end
      if (have && !mem_stall) begin
        if (mi[3:2] == 2'b11) begin
          if (v) q.push_back('{1'b0, rd, a});
        end else if (mi[3] == 1'b0 && mi[2:0] != 3'd3 && mi[2:0] < 3'd6) begin
          sz = (mi[1:0] == 2'd0) ? 1 : (mi[1:0] == 2'd1) ? 2 : 4;
          if ((a % sz) != 0) q.push_back('{1'b1, 5'd0, 32'd0});
          else begin
            exp_addr = a & ~32'd3;
            if (v) q.push_back('{1'b0, rd, fmt(mi[2:0], a[1:0], mem_word(exp_addr))});
          end
        end
        have = 1'b0;
        issued++;
      end
      step();
    end
    dmem_ack = 1'b0;
    nop();
    tests++;
    if (q.size() != 0 || cycles >= 5000) begin
      fails++;
      $display("FAIL rnd_drain: pending=%0d cycles=%0d, required 0 pending within budget", q.size(), cycles);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_lb_lh();
    test_misalign();
    test_stall_hold();
    test_back_to_back();
    test_rd0_load();
    test_reset_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
